// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control blocks.
// Hazard sequencer states, register-index width and the x0 helper live here.
package pipe_ctrl_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

  // Bubble counter width; covers LOAD_STALL_CYC up to 15.
  localparam int BUB_W = 4;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_e;

  // A source operand depends on a destination only if it is actually read
  // and the destination is not the hard-wired zero register.
  function automatic logic src_dep(input logic                 used,
                                   input logic [REG_IDX_W-1:0] rs,
                                   input logic [REG_IDX_W-1:0] rd);
    return used && (rs == rd) && (rd != ZERO_REG);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use / memory-busy / branch-flush sequencer for the 5-stage core.
// Stage enables and flushes are combinational off the registered state.
module hazard_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYC = 1,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 if_id_valid,
  input  logic [REG_IDX_W-1:0] if_id_rs1,
  input  logic [REG_IDX_W-1:0] if_id_rs2,
  input  logic                 if_id_rs1_used,
  input  logic                 if_id_rs2_used,
  input  logic                 id_ex_valid,
  input  logic                 id_ex_rd_mem,
  input  logic [REG_IDX_W-1:0] id_ex_dest_reg_idx,
  input  logic                 ex_take_branch,
  input  logic                 mem_busy,
  output logic                 pc_en,
  output logic                 if_id_en,
  output logic                 id_ex_en,
  output logic                 ex_mem_en,
  output logic                 mem_wb_en,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 stall,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     flush_count
);

  hz_state_e        state_q, state_d, eff_st;
  logic [BUB_W-1:0] bub_q, bub_d;
  logic             lu_hit;
  logic             br_fire;

  assign lu_hit = id_ex_valid && id_ex_rd_mem && if_id_valid &&
                  (src_dep(if_id_rs1_used, if_id_rs1, id_ex_dest_reg_idx) ||
                   src_dep(if_id_rs2_used, if_id_rs2, id_ex_dest_reg_idx));

  // Once memory frees up, this cycle behaves as whichever state we resume into.
  always_comb begin
    eff_st = state_q;
    if (state_q == MEM_WAIT) eff_st = (bub_q != '0) ? LU_STALL : RUN;
  end

  assign br_fire = ex_take_branch && !mem_busy && !reset;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      bub_q   <= '0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
    end
  end

  always_comb begin
    state_d = eff_st;
    bub_d   = bub_q;
    if (mem_busy) begin
      state_d = MEM_WAIT;
    end else if (ex_take_branch) begin
      state_d = RUN;
      bub_d   = '0;
    end else begin
      case (eff_st)
        LU_STALL: begin
          bub_d   = bub_q - BUB_W'(1);
          state_d = (bub_q == BUB_W'(1)) ? RUN : LU_STALL;
        end
        default: begin
          state_d = RUN;
          if (lu_hit && (LOAD_STALL_CYC > 1)) begin
            bub_d   = BUB_W'(LOAD_STALL_CYC - 1);
            state_d = LU_STALL;
          end
        end
      endcase
    end
  end

  always_comb begin
    {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    stall       = 1'b0;
    if (reset) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (mem_busy) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
      stall = 1'b1;
    end else if (ex_take_branch) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if ((eff_st == LU_STALL) || lu_hit) begin
      // Hold PC and IF/ID, push a bubble into ID/EX, let the back end drain.
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
      stall       = 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (stall),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (br_fire),
    .count (flush_count)
  );

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline hazard sequencer for the 5-stage in-order core.
- Sits beside the forwarding unit in ID.
- Detects load-use hazards that forwarding cannot cover, inserts a parameterised number of bubbles, freezes the pipeline on memory busy, and flushes on taken branches.
- Drives per-stage enables/flushes, plus the `stall` input of the forwarding unit and saturating performance counters.

Parameters:
- LOAD_STALL_CYC, 1, bubbles inserted per load-use hazard (1..15).
- CNT_W, 32, width of performance counters.

Ports:
- clock  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- if_id_valid  in  1  IF/ID holds a real instruction.
- if_id_rs1  in  5  source register 1 of the decoding instruction.
- if_id_rs2  in  5  source register 2 of the decoding instruction.
- if_id_rs1_used  in  1  instruction reads rs1.
- if_id_rs2_used  in  1  instruction reads rs2.
- id_ex_valid  in  1  ID/EX holds a real instruction.
- id_ex_rd_mem  in  1  ID/EX instruction is a load.
- id_ex_dest_reg_idx  in  5  ID/EX destination register.
- ex_take_branch  in  1  EX resolves a taken branch/jump this cycle.
- mem_busy  in  1  data memory not ready; whole pipe must hold.
- pc_en  out  1  PC register enable.
- if_id_en  out  1  IF/ID register enable.
- id_ex_en  out  1  ID/EX register enable.
- ex_mem_en  out  1  EX/MEM register enable.
- mem_wb_en  out  1  MEM/WB register enable.
- if_id_flush  out  1  clear IF/ID valid.
- id_ex_flush  out  1  load bubble/clear into ID/EX.
- stall  out  1  hazard stall active; drives forwarding unit `stall`.
- stall_cycles  out  CNT_W  saturating count of cycles with `stall` high.
- flush_count  out  CNT_W  saturating count of branch flushes.

Behaviour:
- Clock and reset are fixed: one clock, `clock`; `reset` is asynchronous and active-high.
- While `reset` is high:
  - state = RUN, bubble counter = 0, both perf counters = 0.
  - all enables = 0, both flushes = 1, stall = 0.
- Load-use detect, combinational (`lu_hit`):
  - id_ex_valid & id_ex_rd_mem & id_ex_dest_reg_idx != 0 & if_id_valid
  - & ((rs1_used & rs1 == dest) | (rs2_used & rs2 == dest)).
- States: RUN, LU_STALL, MEM_WAIT.
- Priority within a cycle: mem_busy > ex_take_branch > lu_hit/LU_STALL.
- mem_busy = 1 (any state):
  - all enables 0, no flushes, stall = 1.
  - Next state MEM_WAIT; the pending bubble count is preserved.
- MEM_WAIT with mem_busy = 0:
  - Return to LU_STALL if bubble count > 0, otherwise RUN.
  - The current cycle is evaluated as that target state.
- ex_take_branch = 1 (no mem_busy):
  - all enables 1, if_id_flush = 1, id_ex_flush = 1, stall = 0.
  - Bubble count cleared, next state RUN, flush_count += 1.
  - A branch cancels any load-use stall in progress.
- RUN with lu_hit:
  - pc_en = 0, if_id_en = 0, id_ex_flush = 1, other enables 1, stall = 1.
  - If LOAD_STALL_CYC > 1: bubble count = LOAD_STALL_CYC-1, next state LU_STALL.
  - Otherwise stay in RUN.
- LU_STALL:
  - Same outputs as a load-use stall.
  - Decrement the count each cycle; go to RUN after the cycle in which it reaches 0.
  - lu_hit is ignored in this state.
- RUN with no hazard: all enables 1, flushes 0, stall 0.
- Latency: outputs are combinational from inputs plus registered state, so they are valid in the same cycle. State and counters update on the rising edge.
- Counters saturate at all-ones and do not wrap.
  - stall_cycles increments on every cycle with stall = 1, including MEM_WAIT.
- rs = x0 never causes a hazard.
- A reset asserted mid-stall aborts the stall immediately, with no residual bubbles.

Decomposition:
- Shared package `pipe_ctrl_pkg`:
  - `hz_state_e` enum {RUN, LU_STALL, MEM_WAIT}.
  - `REG_IDX_W = 5` and the `ZERO_REG` constant.
- One sub-module, `sat_counter` (parameter W; inputs clock, reset, inc; output count), instantiated twice.

Test Plan:
- Load to x5 in ID/EX, `add` using x5 in ID, LOAD_STALL_CYC = 1 -> one cycle of pc_en = 0, if_id_en = 0, id_ex_flush = 1, stall = 1; next cycle all enables 1; stall_cycles = 1.
- Same hazard with LOAD_STALL_CYC = 3 -> exactly 3 consecutive stall cycles, then RUN; stall_cycles = 3.
- Load to x0 with rs1 = 0, or matching rs2 with rs2_used = 0 -> no stall; all enables 1.
- mem_busy high for 4 cycles during the 2nd cycle of a 3-cycle load-use stall -> 4 cycles with all enables 0, then exactly 1 remaining bubble cycle, then RUN; stall_cycles = 7.
- ex_take_branch together with lu_hit -> both flushes 1, pc_en = 1, stall = 0; flush_count = 1; no bubble follows.
- Reset pulse mid-LU_STALL -> during reset enables 0, flushes 1, counters 0; after release, RUN with no residual stall; counters saturate after a forced preload to all-ones.
